// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a source operand is actually read and names the given destination.
  function automatic logic src_hits_dst(input logic       uses,
                                        input logic [4:0] src,
                                        input logic [4:0] dst);
    return uses & (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID operands.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_ex_i,
  input  logic [4:0] wr_addr_ex_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic       uses_rs1_id_i,
  input  logic       uses_rs2_id_i,
  output logic       load_use_o
);

  // A load writing x0 never creates a dependency, so it is excluded.
  assign load_use_o = mem_read_ex_i
                    & (wr_addr_ex_i != REG_X0)
                    & (src_hits_dst(uses_rs1_id_i, rs1_id_i, wr_addr_ex_i)
                     | src_hits_dst(uses_rs2_id_i, rs2_id_i, wr_addr_ex_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: per-stage enables and flushes, data-memory
// wait watchdog, stall-cycle and redirect counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT    = 16,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemReadEX,
  input  logic [4:0]             WriteRegAddrEX,
  input  logic [4:0]             Rs1ID,
  input  logic [4:0]             Rs2ID,
  input  logic                   UsesRs1ID,
  input  logic                   UsesRs2ID,
  input  logic                   RedirectMEM,
  input  logic                   MemReqMEM,
  input  logic                   DmemReady,
  output logic                   EnPC,
  output logic                   EnIFID,
  output logic                   EnIDEX,
  output logic                   EnEXMEM,
  output logic                   EnMEMWB,
  output logic                   FlushIFID,
  output logic                   FlushIDEX,
  output logic                   FlushEXMEM,
  output logic                   MemFault,
  output logic [STALL_CNT_W-1:0] StallCycles,
  output logic [15:0]            FlushCount
);

  localparam int unsigned             WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]       WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [STALL_CNT_W-1:0]  STALL_MAX  = {STALL_CNT_W{1'b1}};
  localparam logic [15:0]             FLUSH_MAX  = 16'hFFFF;

  hz_state_t               state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d, wait_inc_s;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;
  logic [15:0]             flush_cnt_q;
  logic                    mem_fault_q;
  logic                    load_use_s;
  logic                    mem_wait_s;
  logic                    redirect_ok_s;
  logic                    count_stall_s;
  // {PC, IFID, IDEX, EXMEM, MEMWB} and {IFID, IDEX, EXMEM}
  logic [4:0]              en_s;
  logic [2:0]              fl_s;

  load_use_detect u_load_use (
    .mem_read_ex_i (MemReadEX),
    .wr_addr_ex_i  (WriteRegAddrEX),
    .rs1_id_i      (Rs1ID),
    .rs2_id_i      (Rs2ID),
    .uses_rs1_id_i (UsesRs1ID),
    .uses_rs2_id_i (UsesRs2ID),
    .load_use_o    (load_use_s)
  );

  assign mem_wait_s    = MemReqMEM & ~DmemReady;
  assign wait_inc_s    = wait_cnt_q + WAIT_W'(1);
  // A redirect is only taken when the pipeline is live and not held by memory.
  assign redirect_ok_s = (state_q != FAULT) & ~mem_wait_s & RedirectMEM;
  assign count_stall_s = ~en_s[4] & (state_q != FAULT);

  // Steering: fault > memory wait > redirect > load-use > free run.
  always_comb begin
    en_s = 5'b11111;
    fl_s = 3'b000;
    if (!reset) begin
      en_s = 5'b00000;
      fl_s = 3'b000;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mem_wait_s) begin
            en_s = 5'b00000;
            fl_s = 3'b000;
          end else if (RedirectMEM) begin
            en_s = 5'b11111;
            fl_s = 3'b111;
          end else if (load_use_s) begin
            en_s = 5'b00111;
            fl_s = 3'b010;
          end else begin
            en_s = 5'b11111;
            fl_s = 3'b000;
          end
        end
        FAULT: begin
          en_s = 5'b00000;
          fl_s = 3'b000;
        end
        default: begin
          en_s = 5'b00000;
          fl_s = 3'b000;
        end
      endcase
    end
  end

  // Next state and watchdog count; an illegal encoding is treated as a fault.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_wait_s) begin
          wait_cnt_d = wait_inc_s;
          state_d    = (wait_inc_s == WAIT_LIMIT) ? FAULT : MEM_WAIT;
        end else begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end
      end
      FAULT: begin
        state_d    = FAULT;
        wait_cnt_d = wait_cnt_q;
      end
      default: begin
        state_d    = FAULT;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM, watchdog register and sticky fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= (state_d == FAULT);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (count_stall_s && (stall_cnt_q != STALL_MAX)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (redirect_ok_s && (flush_cnt_q != FLUSH_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign {EnPC, EnIFID, EnIDEX, EnEXMEM, EnMEMWB} = en_s;
  assign {FlushIFID, FlushIDEX, FlushEXMEM}       = fl_s;
  assign MemFault    = mem_fault_q;
  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It produces the per-stage enable and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three causes: load-use hazards, branch/JALR redirects resolved in MEM, and data-memory wait states. It also runs a memory-wait watchdog and two performance counters. It sits beside the pipeline registers; every pipeline register's `enable` and flush input is driven only from this block.

## Interface
- `MAX_WAIT`, default 16: maximum consecutive data-memory wait cycles before the block declares a fault.
- `STALL_CNT_W`, default 32: width of the stall-cycle counter.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-low reset. One clock domain only.
- `MemReadEX` in 1: the instruction in EX is a load.
- `WriteRegAddrEX` in 5: destination register of the EX instruction.
- `Rs1ID`, `Rs2ID` in 5 each: source registers of the ID instruction.
- `UsesRs1ID`, `UsesRs2ID` in 1 each: the ID instruction actually reads rs1 / rs2.
- `RedirectMEM` in 1: taken branch or JALR resolved in MEM (`BMEM&BranchMEM | JALRMEM`).
- `MemReqMEM` in 1: the MEM instruction accesses data memory (`MemReadMEM | MemWriteMEM`).
- `DmemReady` in 1: data memory completes the current access this cycle.
- `EnPC`, `EnIFID`, `EnIDEX`, `EnEXMEM`, `EnMEMWB` out 1 each: pipeline register enables.
- `FlushIFID`, `FlushIDEX`, `FlushEXMEM` out 1 each: synchronous bubble insert. Each consumer treats its flush as a clear that takes priority over its enable.
- `MemFault` out 1: watchdog expired. Sticky until reset.
- `StallCycles` out `STALL_CNT_W`: count of cycles with `EnPC`=0. Saturating.
- `FlushCount` out 16: count of accepted redirects. Saturating.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `FAULT`.
- Enables and flushes are combinational from the current state and inputs. Priority, highest first: fault, memory wait, redirect, load-use.
- **FAULT**
  - All enables are 0 and all flushes are 0.
  - `MemFault` = 1.
  - The only exit is `reset`.
- **Memory wait** applies in `RUN` or `MEM_WAIT` when `MemReqMEM & !DmemReady`.
  - All five enables are 0 and all flushes are 0.
  - The FSM goes to or stays in `MEM_WAIT`, and `WaitCnt` increments.
  - If the incremented `WaitCnt` would equal `MAX_WAIT`, the next state is `FAULT`.
  - When `DmemReady` = 1 in `MEM_WAIT`: normal rules apply in that same cycle, the next state is `RUN`, and `WaitCnt` clears to 0.
- **Redirect** applies when `RedirectMEM` = 1 with no memory wait.
  - `FlushIFID` = `FlushIDEX` = `FlushEXMEM` = 1.
  - All enables are 1, so the PC loads the branch target.
  - `FlushCount` increments. Any load-use hazard in the same cycle is ignored, because the instructions involved are flushed.
- **Load-use** is defined as `MemReadEX & WriteRegAddrEX != 0 & ((UsesRs1ID & Rs1ID == WriteRegAddrEX) | (UsesRs2ID & Rs2ID == WriteRegAddrEX))`.
  - `EnPC` = `EnIFID` = 0 and `FlushIDEX` = 1.
  - `EnIDEX` = `EnEXMEM` = `EnMEMWB` = 1.
  - The stall lasts exactly one cycle: the load has moved to MEM on the next cycle.
- **Otherwise:** all enables are 1 and all flushes are 0.
- `StallCycles` increments on every clock edge where `EnPC` = 0 in `RUN` or `MEM_WAIT`. It does not count in `FAULT`.
- Both counters saturate at all-ones.

## Timing
- Zero-cycle latency from inputs to enables/flushes: they are purely combinational. Registered state is only the FSM, `WaitCnt`, the counters and `MemFault`.
- Reset values (while `reset` = 0 and immediately after):
  - state = `RUN`, `WaitCnt` = 0, `StallCycles` = 0, `FlushCount` = 0, `MemFault` = 0.
  - All enables are forced to 0 and all flushes to 0 while `reset` is low.
- Reset asserted mid-`MEM_WAIT` or in `FAULT` returns the block to `RUN` asynchronously. The first cycle after release follows normal rules.
- With `DmemReady` = 1 on the first cycle of a request, no stall occurs and `WaitCnt` stays 0.
- An access needing N wait cycles produces N cycles with all enables at 0. `FAULT` is entered on the edge ending wait cycle `MAX_WAIT`.
- `RedirectMEM` together with a memory wait: the wait wins, and the redirect is applied in the cycle `DmemReady` rises (the inputs are held by the frozen pipeline).

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - `typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} hz_state_t`
  - localparam `REG_X0 = 5'd0`
- Sub-module `load_use_detect` is the purely combinational hazard compare (the equation above), instantiated once.
- The FSM, watchdog and counters live in the top module.

## Test plan
- **Load-use:** `MemReadEX`=1, `WriteRegAddrEX`=5, `Rs2ID`=5, `UsesRs2ID`=1 for one cycle -> `EnPC`=`EnIFID`=0, `FlushIDEX`=1, and `StallCycles` goes 0->1. With `WriteRegAddrEX`=0 instead -> no stall.
- **Redirect with load-use:** `RedirectMEM`=1 together with the load-use inputs -> the three flushes are 1, all enables are 1, and `FlushCount` goes 0->1.
- **Memory wait:** `MemReqMEM`=1 with `DmemReady` low for 3 cycles and then high -> 3 cycles of all enables 0, normal on the 4th cycle, `WaitCnt` back to 0, `StallCycles` = 3.
- **Watchdog:** with `MAX_WAIT`=16 and `DmemReady` held low for 16 cycles -> `MemFault`=1 and all enables 0. Raising `DmemReady` afterwards keeps `FAULT`.
- **Reset mid-wait:** `reset` driven low during cycle 2 of a wait -> counters 0, state `RUN`, `MemFault`=0, and normal operation after release.
- **Saturation:** preload/force `StallCycles` to all-ones minus 1 and stall 3 cycles -> it stays at all-ones.
